// File: rtl/instr_frontend.sv
// rtl/instr_frontend.sv - switch/button instruction entry: sync, debounce, latch, execute strobe
// Optional execute autorepeat while the button is held: define AUTOREPEAT_EN.
module instr_frontend #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned REPEAT_CYCLES   = 5000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_raw,
  input  logic [15:0] sw,
  output logic [3:0]  opcode,
  output logic [11:0] instr,
  output logic        btn_edge,
  output logic        pressed
);

  localparam logic [15:0] DbLast = 16'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, DB_PRESS, PRESSED, DB_RELEASE} state_e;

  logic        btn_meta_q, btn_s_q;
  logic [15:0] sw_meta_q, sw_s_q;
  state_e      state_q, state_d;
  logic [15:0] db_cnt_q, db_cnt_d;
  logic [15:0] word_q, word_d;
  logic        edge_q, edge_d;
  logic        fire;

`ifdef AUTOREPEAT_EN
  localparam logic [23:0] RptLast = 24'(REPEAT_CYCLES - 1);
  logic [23:0] rpt_cnt_q, rpt_cnt_d;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      btn_meta_q <= 1'b0;
      btn_s_q    <= 1'b0;
      sw_meta_q  <= '0;
      sw_s_q     <= '0;
    end else begin
      btn_meta_q <= btn_raw;
      btn_s_q    <= btn_meta_q;
      sw_meta_q  <= sw;
      sw_s_q     <= sw_meta_q;
    end
  end

  always_comb begin
    state_d  = state_q;
    db_cnt_d = db_cnt_q;
    word_d   = word_q;
    edge_d   = 1'b0;
    fire     = 1'b0;
`ifdef AUTOREPEAT_EN
    // Zero unless counting in PRESSED, so every entry to PRESSED starts fresh.
    rpt_cnt_d = '0;
`endif
    unique case (state_q)
      IDLE: begin
        if (btn_s_q) begin
          state_d  = DB_PRESS;
          db_cnt_d = '0;
        end
      end
      DB_PRESS: begin
        if (!btn_s_q) begin
          state_d = IDLE;
        end else if (db_cnt_q == DbLast) begin
          state_d = PRESSED;
          fire    = 1'b1;
        end else begin
          db_cnt_d = db_cnt_q + 16'd1;
        end
      end
      PRESSED: begin
        if (!btn_s_q) begin
          state_d  = DB_RELEASE;
          db_cnt_d = '0;
        end
`ifdef AUTOREPEAT_EN
        else if (rpt_cnt_q == RptLast) begin
          fire = 1'b1;
        end else begin
          rpt_cnt_d = rpt_cnt_q + 24'd1;
        end
`endif
      end
      DB_RELEASE: begin
        if (btn_s_q) begin
          state_d = PRESSED;
        end else if (db_cnt_q == DbLast) begin
          state_d = IDLE;
        end else begin
          db_cnt_d = db_cnt_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (fire) begin
      word_d = sw_s_q;
      edge_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      db_cnt_q <= '0;
      word_q   <= '0;
      edge_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      db_cnt_q <= db_cnt_d;
      word_q   <= word_d;
      edge_q   <= edge_d;
    end
  end

`ifdef AUTOREPEAT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      rpt_cnt_q <= '0;
    end else begin
      rpt_cnt_q <= rpt_cnt_d;
    end
  end
`endif

  assign opcode   = word_q[15:12];
  assign instr    = word_q[11:0];
  assign btn_edge = edge_q;
  assign pressed  = (state_q == PRESSED) || (state_q == DB_RELEASE);

endmodule

// File: tb/tb_instr_frontend.sv
// tb/tb_instr_frontend.sv - scoreboard bench for instr_frontend at several debounce lengths
module tb_instr_frontend;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] sw;
  logic        btn4, btn8, btn1, btn2;
  logic [3:0]  op4, op8, op1, op2;
  logic [11:0] in4, in8, in1, in2;
  logic        e4, e8, e1, e2;
  logic        p4, p8, p1, p2;

  typedef struct {
    int          edge_no;
    logic [15:0] word;
  } exp_t;

  exp_t sbq[$];
  exp_t ex;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  instr_frontend #(.DEBOUNCE_CYCLES(4), .REPEAT_CYCLES(10)) u_db4 (
    .clk(clk), .rst(rst), .btn_raw(btn4), .sw(sw),
    .opcode(op4), .instr(in4), .btn_edge(e4), .pressed(p4));
  instr_frontend #(.DEBOUNCE_CYCLES(8), .REPEAT_CYCLES(10)) u_db8 (
    .clk(clk), .rst(rst), .btn_raw(btn8), .sw(sw),
    .opcode(op8), .instr(in8), .btn_edge(e8), .pressed(p8));
  instr_frontend #(.DEBOUNCE_CYCLES(1), .REPEAT_CYCLES(10)) u_db1 (
    .clk(clk), .rst(rst), .btn_raw(btn1), .sw(sw),
    .opcode(op1), .instr(in1), .btn_edge(e1), .pressed(p1));
  instr_frontend #(.DEBOUNCE_CYCLES(2), .REPEAT_CYCLES(10)) u_db2 (
    .clk(clk), .rst(rst), .btn_raw(btn2), .sw(sw),
    .opcode(op2), .instr(in2), .btn_edge(e2), .pressed(p2));

  // Inputs change on the falling edge; edge k samples what was driven before it.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; sw = 16'hFFFF;
    btn4 = 1'b1; btn8 = 1'b1; btn1 = 1'b1; btn2 = 1'b1;
    repeat (3) tick();
    n_cmp++; if ({op4, in4, e4, p4} !== 18'h0) begin n_bad++; $display("FAIL reset_db4: got %h want 0", {op4, in4, e4, p4}); end
    n_cmp++; if ({op8, in8, e8, p8} !== 18'h0) begin n_bad++; $display("FAIL reset_db8: got %h want 0", {op8, in8, e8, p8}); end
    n_cmp++; if ({op1, in1, e1, p1} !== 18'h0) begin n_bad++; $display("FAIL reset_db1: got %h want 0", {op1, in1, e1, p1}); end
    n_cmp++; if ({op2, in2, e2, p2} !== 18'h0) begin n_bad++; $display("FAIL reset_db2: got %h want 0", {op2, in2, e2, p2}); end
    btn4 = 1'b0; btn8 = 1'b0; btn1 = 1'b0; btn2 = 1'b0; rst = 1'b0;
    for (int k = 0; k < 12; k++) begin
      tick();
      n_cmp++;
      if ({e4, e8, e1, e2, p4, p8, p1, p2} !== 8'h0) begin
        n_bad++; $display("FAIL reset_idle: cycle %0d strobes/pressed %b want 0", k, {e4, e8, e1, e2, p4, p8, p1, p2});
      end
    end
  endtask

  task automatic test_clean_press();
    sw = 16'h3A5C;
    sbq.delete();
    sbq.push_back('{edge_no: 6, word: 16'h3A5C});
    for (int k = 0; k < 23; k++) begin
      btn4 = (k < 12);
      if (k == 8) sw = 16'hFFFF;
      tick();
      if (e4) begin
        n_cmp++;
        if (sbq.size() == 0) begin
          n_bad++; $display("FAIL clean_edge: unexpected btn_edge at edge %0d", k);
        end else begin
          ex = sbq.pop_front();
          if (k != ex.edge_no || {op4, in4} !== ex.word) begin
            n_bad++; $display("FAIL clean_edge: edge %0d word %h want edge %0d word %h", k, {op4, in4}, ex.edge_no, ex.word);
          end
        end
      end
      n_cmp++;
      if (p4 !== (k >= 6 && k < 18)) begin
        n_bad++; $display("FAIL clean_pressed: edge %0d got %b want %b", k, p4, (k >= 6 && k < 18));
      end
    end
    n_cmp++; if (sbq.size() != 0) begin n_bad++; $display("FAIL clean_missing: %0d strobes never seen want 0", sbq.size()); end
    n_cmp++; if ({op4, in4} !== 16'h3A5C) begin n_bad++; $display("FAIL clean_hold: got %h want 3a5c", {op4, in4}); end
  endtask

  task automatic test_bounce();
    sw = 16'h1234;
    for (int k = 0; k < 20; k++) begin
      btn4 = (k < 8) ? ((k % 4) < 2) : 1'b0;
      tick();
      n_cmp++;
      if ({e4, p4} !== 2'b00) begin
        n_bad++; $display("FAIL bounce: edge %0d btn_edge/pressed %b want 00", k, {e4, p4});
      end
    end
    n_cmp++; if ({op4, in4} !== 16'h3A5C) begin n_bad++; $display("FAIL bounce_word: got %h want 3a5c", {op4, in4}); end
  endtask

  task automatic test_sw_change_rebounce();
    sw = 16'h5123;
    sbq.delete();
    sbq.push_back('{edge_no: 6, word: 16'h5123});
    for (int k = 0; k < 31; k++) begin
      btn4 = (k < 12) || (k >= 15 && k < 18);
      if (k == 8) sw = 16'hFFFF;
      tick();
      if (e4) begin
        n_cmp++;
        if (sbq.size() == 0) begin
          n_bad++; $display("FAIL rebounce_edge: unexpected btn_edge at edge %0d", k);
        end else begin
          ex = sbq.pop_front();
          if (k != ex.edge_no || {op4, in4} !== ex.word) begin
            n_bad++; $display("FAIL rebounce_edge: edge %0d word %h want edge %0d word %h", k, {op4, in4}, ex.edge_no, ex.word);
          end
        end
      end
      n_cmp++;
      if (p4 !== (k >= 6 && k < 24)) begin
        n_bad++; $display("FAIL rebounce_pressed: edge %0d got %b want %b", k, p4, (k >= 6 && k < 24));
      end
    end
    n_cmp++; if (sbq.size() != 0) begin n_bad++; $display("FAIL rebounce_missing: %0d strobes never seen want 0", sbq.size()); end
    n_cmp++; if ({op4, in4} !== 16'h5123) begin n_bad++; $display("FAIL rebounce_word: got %h want 5123", {op4, in4}); end
  endtask

  task automatic test_reset_mid_debounce();
    sw = 16'h7E81;
    sbq.delete();
    sbq.push_back('{edge_no: 10, word: 16'h7E81});
    for (int k = 0; k < 30; k++) begin
      btn8 = (k < 12);
      tick();
      if (e8) begin
        n_cmp++;
        if (sbq.size() == 0) begin
          n_bad++; $display("FAIL db8_edge: unexpected btn_edge at edge %0d", k);
        end else begin
          ex = sbq.pop_front();
          if (k != ex.edge_no || {op8, in8} !== ex.word) begin
            n_bad++; $display("FAIL db8_edge: edge %0d word %h want edge %0d word %h", k, {op8, in8}, ex.edge_no, ex.word);
          end
        end
      end
    end
    n_cmp++; if (sbq.size() != 0) begin n_bad++; $display("FAIL db8_missing: %0d strobes never seen want 0", sbq.size()); end
    // Second press: abort with reset once the debounce count has reached 5.
    sw = 16'h1111;
    for (int k = 0; k < 8; k++) begin
      btn8 = 1'b1;
      tick();
      n_cmp++;
      if (e8 !== 1'b0) begin n_bad++; $display("FAIL abort_early: btn_edge at edge %0d want 0", k); end
    end
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      tick();
      n_cmp++;
      if ({op8, in8, e8, p8} !== 18'h0) begin
        n_bad++; $display("FAIL abort_reset: cycle %0d got %h want 0", k, {op8, in8, e8, p8});
      end
    end
    rst = 1'b0;
    sbq.push_back('{edge_no: 10, word: 16'h1111});
    for (int k = 0; k < 35; k++) begin
      btn8 = (k < 12);
      tick();
      if (e8) begin
        n_cmp++;
        if (sbq.size() == 0) begin
          n_bad++; $display("FAIL abort_edge: unexpected btn_edge at edge %0d", k);
        end else begin
          ex = sbq.pop_front();
          if (k != ex.edge_no || {op8, in8} !== ex.word) begin
            n_bad++; $display("FAIL abort_edge: edge %0d word %h want edge %0d word %h", k, {op8, in8}, ex.edge_no, ex.word);
          end
        end
      end
    end
    n_cmp++; if (sbq.size() != 0) begin n_bad++; $display("FAIL abort_missing: %0d strobes never seen want 0", sbq.size()); end
  endtask

  task automatic test_min_debounce();
    sw = 16'h9C3F;
    sbq.delete();
    sbq.push_back('{edge_no: 3, word: 16'h9C3F});
    for (int k = 0; k < 13; k++) begin
      btn1 = (k < 6);
      tick();
      if (e1) begin
        n_cmp++;
        if (sbq.size() == 0) begin
          n_bad++; $display("FAIL min_edge: unexpected btn_edge at edge %0d", k);
        end else begin
          ex = sbq.pop_front();
          if (k != ex.edge_no || {op1, in1} !== ex.word) begin
            n_bad++; $display("FAIL min_edge: edge %0d word %h want edge %0d word %h", k, {op1, in1}, ex.edge_no, ex.word);
          end
        end
      end
      n_cmp++;
      if (p1 !== (k >= 3 && k < 9)) begin
        n_bad++; $display("FAIL min_pressed: edge %0d got %b want %b", k, p1, (k >= 3 && k < 9));
      end
    end
    n_cmp++; if (sbq.size() != 0) begin n_bad++; $display("FAIL min_missing: %0d strobes never seen want 0", sbq.size()); end
    sw = 16'h0F0F;
    for (int k = 0; k < 8; k++) begin
      btn1 = (k == 0);
      tick();
      n_cmp++;
      if ({e1, p1} !== 2'b00) begin n_bad++; $display("FAIL min_glitch: edge %0d btn_edge/pressed %b want 00", k, {e1, p1}); end
    end
    n_cmp++; if ({op1, in1} !== 16'h9C3F) begin n_bad++; $display("FAIL min_word: got %h want 9c3f", {op1, in1}); end
  endtask

  task automatic test_autorepeat();
    sw = 16'hC0DE;
    sbq.delete();
    sbq.push_back('{edge_no: 4, word: 16'hC0DE});
`ifdef AUTOREPEAT_EN
    sbq.push_back('{edge_no: 14, word: 16'hC0DE});
    sbq.push_back('{edge_no: 24, word: 16'hBEEF});
    sbq.push_back('{edge_no: 34, word: 16'hBEEF});
`endif
    for (int k = 0; k < 55; k++) begin
      btn2 = (k < 40);
      if (k == 20) sw = 16'hBEEF;
      tick();
      if (e2) begin
        n_cmp++;
        if (sbq.size() == 0) begin
          n_bad++; $display("FAIL repeat_edge: unexpected btn_edge at edge %0d", k);
        end else begin
          ex = sbq.pop_front();
          if (k != ex.edge_no || {op2, in2} !== ex.word) begin
            n_bad++; $display("FAIL repeat_edge: edge %0d word %h want edge %0d word %h", k, {op2, in2}, ex.edge_no, ex.word);
          end
        end
      end
    end
    n_cmp++; if (sbq.size() != 0) begin n_bad++; $display("FAIL repeat_missing: %0d strobes never seen want 0", sbq.size()); end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_sw_change_rebounce();
    test_reset_mid_debounce();
    test_min_debounce();
    test_autorepeat();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/instr_frontend.md
INSTR_FRONTEND -- requirements
Module: instr_frontend

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 50000, is the number of consecutive cycles a synchronised button level must hold to be accepted; legal range 1..65535.
REQ-002 Parameter REPEAT_CYCLES, default 5000000, is the autorepeat interval in cycles; it is used only when AUTOREPEAT_EN is defined; legal range 1..2^24-1.
REQ-003 Port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 Port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 Port btn_raw, input, 1 bit: asynchronous, bouncy execute push-button; 1 means pressed.
REQ-006 Port sw, input, 16 bits: asynchronous instruction switches; [15:12] are the opcode and [11:0] are the instruction body.
REQ-007 Port opcode, output, 4 bits: latched sw[15:12], fed to the CPU core opcode input.
REQ-008 Port instr, output, 12 bits: latched sw[11:0], fed to the CPU core instr input.
REQ-009 Port btn_edge, output, 1 bit: single-cycle execute strobe, fed to the CPU core btn_edge input.
REQ-010 Port pressed, output, 1 bit: debounced button level; 1 in states PRESSED and DB_RELEASE.

Function
REQ-011 btn_raw and sw shall each pass through a two-flop synchroniser, producing btn_s and sw_s; no other logic shall read the raw inputs.
REQ-012 The FSM shall have states IDLE, DB_PRESS, PRESSED and DB_RELEASE, plus a 16-bit debounce counter db_cnt.
REQ-013 In IDLE with btn_s=1, the FSM shall go to DB_PRESS with db_cnt=0; with btn_s=0 it shall stay in IDLE.
REQ-014 In DB_PRESS with btn_s=0, the FSM shall return to IDLE.
REQ-015 In DB_PRESS with btn_s=1 and db_cnt<DEBOUNCE_CYCLES-1, db_cnt shall increment.
REQ-016 In DB_PRESS with btn_s=1 and db_cnt=DEBOUNCE_CYCLES-1, the FSM shall go to PRESSED; on that same edge it shall load opcode/instr from sw_s and register btn_edge=1.
REQ-017 btn_edge shall be high for exactly one cycle per accepted press, and shall coincide with the first cycle in which the new opcode/instr are visible.
REQ-018 Latency: for a clean press, btn_edge shall rise at edge number DEBOUNCE_CYCLES+2 counted from the first edge that samples btn_raw=1 (edge 0).
REQ-019 In PRESSED with btn_s=0, the FSM shall go to DB_RELEASE with db_cnt=0.
REQ-020 In DB_RELEASE with btn_s=1, the FSM shall return to PRESSED with no new btn_edge.
REQ-021 In DB_RELEASE, db_cnt shall count as in REQ-015; at db_cnt=DEBOUNCE_CYCLES-1 with btn_s=0, the FSM shall go to IDLE.
REQ-022 opcode/instr shall change only on a btn_edge load; sw changes at any other time shall have no effect on the outputs.
REQ-023 With DEBOUNCE_CYCLES=1, a press shall be accepted on the second cycle of btn_s=1, and db_cnt shall not overflow.
REQ-024 Bounce shorter than DEBOUNCE_CYCLES, whether during press or release, shall produce no btn_edge.

Reset
REQ-025 While rst=1: state=IDLE, db_cnt=0, the repeat counter=0, both synchroniser stages=0, opcode=0, instr=0, btn_edge=0 and pressed=0.
REQ-026 Reset asserted mid-debounce or while PRESSED shall abort the press and emit no btn_edge; after release of reset the button shall be held again for the full debounce before it is accepted.

Configuration
REQ-027 When macro AUTOREPEAT_EN is defined, a 24-bit repeat counter shall run in PRESSED while btn_s=1.
REQ-028 With AUTOREPEAT_EN defined, when the repeat counter reaches REPEAT_CYCLES-1, the block shall reload opcode/instr from sw_s, pulse btn_edge for one cycle and clear the counter.
REQ-029 With AUTOREPEAT_EN defined, the repeat counter shall clear on every entry to PRESSED, including the return from DB_RELEASE.
REQ-030 When AUTOREPEAT_EN is not defined, no repeat counter shall exist and each accepted press shall yield exactly one btn_edge.

Verification
REQ-031 Scenario: DEBOUNCE_CYCLES=4, sw=16'h3A5C, clean hold of btn_raw -> btn_edge high for one cycle starting at edge 6, opcode=4'h3 and instr=12'hA5C in that same cycle.
REQ-032 Scenario: DEBOUNCE_CYCLES=4, btn_raw toggles 1,0,1,0 every 2 cycles and then stays 0 -> btn_edge never asserted, pressed stays 0.
REQ-033 Scenario: a press is accepted, then sw changes to 16'hFFFF while held, then release and a 3-cycle re-bounce occur -> opcode/instr unchanged and no second btn_edge.
REQ-034 Scenario: DEBOUNCE_CYCLES=8, rst asserted when db_cnt=5 in DB_PRESS -> no btn_edge and all outputs 0; holding the button afterwards gives btn_edge at edge 10 after reset release.
REQ-035 Scenario: AUTOREPEAT_EN defined, DEBOUNCE_CYCLES=2, REPEAT_CYCLES=10, button held for 40 cycles -> one initial btn_edge then one repeat btn_edge every 10 cycles; without the macro, exactly one btn_edge.
